rx_sram_wr: RTL

Receive-side frame writer placed between the MAC RX byte stream and port 0 (RW) of the `sky130_sram_1kbyte_1rw1r_8x1024_8` packet buffer. It writes incoming bytes into the SRAM as a circular buffer, commits good frames as descriptors (start address, length) through a 4-entry descriptor FIFO, and rolls back frames that are errored, truncated, or overflow the buffer. The downstream reader drains frames through SRAM port 1 and returns space by advancing `rd_ptr`.

---
 rtl/rx_sram_wr.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/rx_sram_wr.sv
// rx_sram_wr: writes the MAC RX byte stream into a circular SRAM packet
// buffer through port 0 and publishes completed good frames as
// {start address, length} descriptors through a small FIFO. Frames that are
// errored, truncated by a new sof, overflow the ring, or find the FIFO full
// are rolled back by rewinding the write pointer.
module rx_sram_wr #(
  parameter int ADDR_W     = 10,
  parameter int DESC_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_sof,
  input  logic              rx_eof,
  input  logic              rx_err,
  input  logic [ADDR_W-1:0] rd_ptr,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic              sram_wmask0,
  output logic [ADDR_W-1:0] sram_addr0,
  output logic [7:0]        sram_din0,
  output logic              frm_valid,
  input  logic              frm_ready,
  output logic [ADDR_W-1:0] frm_addr,
  output logic [ADDR_W:0]   frm_len,
  output logic [15:0]       drop_cnt
);

  localparam int IDX_W = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   base_ptr;
  logic [ADDR_W:0]     len;

  // Descriptor FIFO storage and bookkeeping
  logic [ADDR_W-1:0]   fifo_addr [DESC_DEPTH];
  logic [ADDR_W:0]     fifo_len  [DESC_DEPTH];
  logic [IDX_W-1:0]    fifo_wr_idx;
  logic [IDX_W-1:0]    fifo_rd_idx;
  logic [CNT_W-1:0]    fifo_cnt;

  // Commit pipeline: descriptor is pushed one edge after the eof byte
  logic                vld_p1;
  logic [ADDR_W-1:0]   desc_addr_p1;
  logic [ADDR_W:0]     desc_len_p1;

  // Per-byte decode
  logic                in_recv;
  logic                accept;
  logic                abort;
  logic [ADDR_W-1:0]   eff_base;
  logic [ADDR_W-1:0]   eff_wr;
  logic [ADDR_W:0]     eff_len;
  logic [ADDR_W:0]     len_next;
  logic [ADDR_W-1:0]   space;
  logic                no_space;
  logic [CNT_W-1:0]    fifo_cnt_eff;
  logic                fifo_full;
  logic                wr_en;
  logic                commit;
  logic                frame_drop;
  logic [1:0]          drop_inc;
  logic                pop;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign sram_wmask0 = 1'b1;
  assign frm_valid   = (fifo_cnt != '0);
  assign pop         = frm_valid && frm_ready;
  assign frm_addr    = frm_valid ? fifo_addr[fifo_rd_idx] : '0;
  assign frm_len     = frm_valid ? fifo_len[fifo_rd_idx]  : '0;

  // Decode the current byte: which frame it belongs to, where it lands, and its fate.
  // A sof inside RECV restarts at the old base, so the aborted bytes are overwritten.
  always_comb begin
    in_recv      = (state == RECV);
    accept       = rx_valid && (rx_sof || in_recv);
    abort        = rx_valid && rx_sof && in_recv;
    eff_base     = in_recv ? base_ptr : wr_ptr;
    eff_wr       = (in_recv && !rx_sof) ? wr_ptr : eff_base;
    eff_len      = rx_sof ? '0 : len;
    len_next     = eff_len + (ADDR_W+1)'(1);
    space        = rd_ptr - eff_wr - ADDR_W'(1);
    no_space     = (space == '0);
    // Occupancy as it will stand after this edge, counting the in-flight push and a pop
    fifo_cnt_eff = fifo_cnt + CNT_W'(vld_p1) - CNT_W'(pop);
    fifo_full    = (fifo_cnt_eff >= CNT_W'(DESC_DEPTH));
    wr_en        = accept && !no_space;
    commit       = wr_en && rx_eof && !rx_err && !fifo_full;
    frame_drop   = accept && (no_space || (rx_eof && (rx_err || fifo_full)));
    drop_inc     = 2'(abort) + 2'(frame_drop);
  end

  // Frame FSM with pointer bookkeeping and the registered SRAM write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      base_ptr   <= '0;
      len        <= '0;
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
    end else begin
      sram_csb0 <= !wr_en;
      sram_web0 <= !wr_en;
      if (wr_en) begin
        sram_addr0 <= eff_wr;
        sram_din0  <= rx_data;
      end
      if (accept) begin
        base_ptr <= eff_base;
        if (no_space) begin
          wr_ptr <= eff_base;
          len    <= '0;
          state  <= rx_eof ? IDLE : DROP;
        end else if (rx_eof) begin
          wr_ptr <= commit ? (eff_wr + ADDR_W'(1)) : eff_base;
          len    <= '0;
          state  <= IDLE;
        end else begin
          wr_ptr <= eff_wr + ADDR_W'(1);
          len    <= len_next;
          state  <= RECV;
        end
      end else if (rx_valid && rx_eof && (state == DROP)) begin
        state <= IDLE;
      end
    end
  end

  // Commit stage valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= commit;
  end

  // ---- p1: descriptor captured at the eof edge, pushed on the next edge ----
  always_ff @(posedge clk) begin
    if (commit) begin
      desc_addr_p1 <= eff_base;
      desc_len_p1  <= len_next;
    end
  end

  // Descriptor FIFO storage; reads are gated by frm_valid so no reset is needed
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      fifo_addr[fifo_wr_idx] <= desc_addr_p1;
      fifo_len[fifo_wr_idx]  <= desc_len_p1;
    end
  end

  // Descriptor FIFO pointers and occupancy; simultaneous push and pop allowed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_idx <= '0;
      fifo_rd_idx <= '0;
      fifo_cnt    <= '0;
    end else begin
      if (vld_p1) fifo_wr_idx <= fifo_wr_idx + IDX_W'(1);
      if (pop)    fifo_rd_idx <= fifo_rd_idx + IDX_W'(1);
      fifo_cnt <= fifo_cnt + CNT_W'(vld_p1) - CNT_W'(pop);
    end
  end

  // Saturating dropped-frame counter; an abort and a drop can land on one byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt <= '0;
    else        drop_cnt <= sat_add16(drop_cnt, drop_inc);
  end

endmodule
